// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Stopwatch core: takes the already-synchronized button levels, detects
//   their rising edges, runs the IDLE/CLEAR/RUNNING mode FSM, divides clk down
//   to a centisecond tick and keeps an MM:SS.CC time in BCD.
//
// Parameters
//   DIV       clk cycles per centisecond tick (DIV >= 2)
//
// Ports
//   clk       in   1  system clock, all state on rising edge
//   rst       in   1  asynchronous reset, active-low (0 = reset)
//   btn       in   3  button levels: [2]=IDLE/stop, [1]=CLEAR, [0]=RUN
//   mode      out  3  one-hot state: 100 IDLE, 010 CLEAR, 001 RUNNING
//   cs_bcd    out  8  centiseconds, two BCD digits 00-99
//   sec_bcd   out  8  seconds, two BCD digits 00-59
//   min_bcd   out  8  minutes, two BCD digits 00-59
//   tick      out  1  one-cycle pulse after each centisecond increment
//   rollover  out  1  one-cycle pulse when the time wraps 59:59.99 -> 00:00.00
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  output logic [2:0] mode,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       tick,
  output logic       rollover
);

  localparam int PW = $clog2(DIV);

  // State encodings double as the one-hot mode output.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b100,
    S_CLEAR = 3'b010,
    S_RUN   = 3'b001
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [2:0]     r_btn_prev;
  logic [2:0]     w_press;
  logic [PW-1:0]  r_presc;
  logic [PW-1:0]  w_presc_next;
  logic [7:0]     r_cs;
  logic [7:0]     r_sec;
  logic [7:0]     r_min;
  logic [7:0]     w_cs_next;
  logic [7:0]     w_sec_next;
  logic [7:0]     w_min_next;
  logic           r_tick;
  logic           r_rollover;
  logic           w_presc_wrap;
  logic           w_inc;
  logic           w_zero;
  logic           w_cs_max;
  logic           w_sec_max;
  logic           w_min_max;

  // Two-digit BCD increment that wraps to 00 after 'top'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign w_press = btn & ~r_btn_prev;

  // Next-state logic. Priority among simultaneous presses is CLEAR > IDLE > RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_press[1])      w_state_next = S_CLEAR;
        else if (w_press[0]) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_press[1])      w_state_next = S_CLEAR;
        else if (w_press[2]) w_state_next = S_IDLE;
      end
      S_CLEAR: begin
        if (w_press[2])      w_state_next = S_IDLE;
        else if (w_press[0]) w_state_next = S_RUN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_presc_wrap = (r_presc == PW'(DIV - 1));
  // Increment is decided by the current state, so it still lands on the edge
  // that leaves RUNNING for IDLE.
  assign w_inc        = (r_state == S_RUN) && w_presc_wrap;
  // Zeroing covers both sitting in CLEAR and the edge entering CLEAR, which
  // overrides any increment due on that edge.
  assign w_zero       = (r_state == S_CLEAR) || (w_state_next == S_CLEAR);

  assign w_cs_max  = (r_cs  == 8'h99);
  assign w_sec_max = (r_sec == 8'h59);
  assign w_min_max = (r_min == 8'h59);

  always_comb begin
    w_presc_next = r_presc;
    if (w_zero)
      w_presc_next = '0;
    else if (r_state == S_RUN)
      w_presc_next = w_presc_wrap ? '0 : r_presc + PW'(1);
  end

  // Hold path re-assigns the current value so the time registers are written
  // every cycle.
  always_comb begin
    w_cs_next  = r_cs;
    w_sec_next = r_sec;
    w_min_next = r_min;
    if (w_zero) begin
      w_cs_next  = 8'h00;
      w_sec_next = 8'h00;
      w_min_next = 8'h00;
    end else if (w_inc) begin
      w_cs_next = bcd_inc(r_cs, 8'h99);
      if (w_cs_max) begin
        w_sec_next = bcd_inc(r_sec, 8'h59);
        if (w_sec_max)
          w_min_next = bcd_inc(r_min, 8'h59);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_btn_prev <= 3'b000;
      r_presc    <= '0;
      r_cs       <= 8'h00;
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_btn_prev <= btn;
      r_presc    <= w_presc_next;
      r_cs       <= w_cs_next;
      r_sec      <= w_sec_next;
      r_min      <= w_min_next;
      r_tick     <= w_inc && !w_zero;
      r_rollover <= w_inc && !w_zero && w_cs_max && w_sec_max && w_min_max;
    end
  end

  assign mode     = r_state;
  assign cs_bcd   = r_cs;
  assign sec_bcd  = r_sec;
  assign min_bcd  = r_min;
  assign tick     = r_tick;
  assign rollover = r_rollover;

endmodule
